uart_receive: RTL
=================

UART_RECEIVE -- requirements
Module: uart_receive

Interface
REQ-001 Parameter OVERSAMPLE, default 16, is the number of SAMPLE_TICK pulses per bit period; legal values are even integers from 4 to 64.
REQ-002 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-high reset.
REQ-004 RX  input  1  asynchronous serial line; idles high; frame is 1 start(0), 8 data (LSB first), 1 stop(1).
REQ-005 SAMPLE_TICK  input  1  one-CLK-cycle enable pulse at OVERSAMPLE x baud rate.
REQ-006 RXACK  input  1  consumer acknowledge; clears RXVALID.
REQ-007 RXDATA  output  8  last correctly received byte.
REQ-008 RXVALID  output  1  RXDATA holds an unconsumed byte.
REQ-009 RXBUSY  output  1  a frame is in progress.
REQ-010 FRAME_ERR  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-011 OVERRUN  output  1  sticky flag: a good byte arrived while RXVALID=1.

Function
REQ-012 RX passes through a 2-flop synchronizer (both flops reset to 1); all decisions use the synchronized value RXS and its previous value RXS_D (reset 1).
REQ-013 FSM states: IDLE, START, DATA, STOP; a tick counter of ceil(log2(OVERSAMPLE)) bits and a 3-bit bit counter advance only on cycles with SAMPLE_TICK=1.
REQ-014 IDLE -> START on the cycle RXS_D=1 and RXS=0 (falling edge), regardless of SAMPLE_TICK; tick counter cleared; a line held low does not retrigger.
REQ-015 START: on the tick where the counter reaches OVERSAMPLE/2-1, sample RXS; 0 -> DATA with tick counter cleared; 1 -> IDLE (false start, no flag).
REQ-016 DATA: on the tick where the counter reaches OVERSAMPLE-1, shift RXS into the MSB of an 8-bit shift register (right shift), clear the tick counter, and increment the bit counter; after the 8th sample -> STOP.
REQ-017 STOP: on the tick where the counter reaches OVERSAMPLE-1, sample RXS and return to IDLE.
REQ-018 Stop bit = 1 -> on the next CLK edge, RXDATA <= shift register and RXVALID <= 1.
REQ-019 Stop bit = 1 with RXVALID already 1 and RXACK=0 -> RXDATA and RXVALID unchanged, OVERRUN <= 1, byte dropped.
REQ-020 Stop bit = 0 -> FRAME_ERR pulses for exactly one cycle; RXDATA, RXVALID, OVERRUN unchanged.
REQ-021 RXACK=1 clears RXVALID and OVERRUN on the next edge; RXACK with RXVALID=0 has no effect.
REQ-022 RXACK coincident with a good-stop load: the new byte is loaded, RXVALID stays 1, OVERRUN is cleared and not set.
REQ-023 RXBUSY = 1 exactly while the state is START, DATA or STOP (registered with the state).
REQ-024 Latency: RXVALID rises one CLK cycle after the SAMPLE_TICK cycle that samples the stop bit.
REQ-025 A new falling edge seen in START, DATA or STOP is ignored; edge detection is active only in IDLE.

Reset
REQ-026 RESET=1 asynchronously forces: state IDLE, counters 0, shift register 0, synchronizer/RXS_D 1, RXDATA 8'h00, RXVALID 0, RXBUSY 0, FRAME_ERR 0, OVERRUN 0.
REQ-027 RESET asserted mid-frame abandons the frame with no RXVALID or FRAME_ERR; after release, reception resumes only on a fresh falling edge.

Verification
REQ-028 OVERSAMPLE=16, send 8'hA5 with a good stop -> RXDATA=8'hA5, RXVALID=1 one cycle after the stop sample; RXBUSY low from that point.
REQ-029 8'h3C then 8'hC3 back to back with no RXACK -> RXDATA stays 8'h3C and OVERRUN=1; RXACK -> RXVALID=0 and OVERRUN=0.
REQ-030 Send 8'h55 with stop bit driven 0 -> single-cycle FRAME_ERR, RXVALID stays 0, and no new frame until RX returns high then falls.
REQ-031 A 0 glitch of 4 tick periods on idle RX -> START entered then IDLE, with RXVALID/FRAME_ERR never asserted and RXBUSY high for about 8 ticks.
REQ-032 RESET pulse during bit 4 of a frame -> all outputs at reset values; the next full frame 8'h0F is received correctly.
REQ-033 RXACK in the same cycle as a good 8'h7E load, with RXVALID=1 -> RXDATA=8'h7E, RXVALID=1, OVERRUN=0.

Source files
------------

// File: rtl/uart_receive.sv
// 8N1 UART receiver driven by an external oversampling tick enable.
// Mid-bit sampling, single-entry holding register with overrun and framing error flags.
module uart_receive #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       sample_tick,
    input  logic       rxack,
    output logic [7:0] rxdata,
    output logic       rxvalid,
    output logic       rxbusy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rxs_q, rxs_d_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          rxvalid_q, rxvalid_d;
    logic          rxbusy_q, rxbusy_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          stop_done, stop_good;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_d_q     <= 1'b1;
            state_q     <= IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            rxdata_q    <= '0;
            rxvalid_q   <= 1'b0;
            rxbusy_q    <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            rxs_q       <= sync1_q;
            rxs_d_q     <= rxs_q;
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            rxdata_q    <= rxdata_d;
            rxvalid_q   <= rxvalid_d;
            rxbusy_q    <= rxbusy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        stop_done = 1'b0;
        stop_good = 1'b0;

        case (state_q)
            IDLE: begin
                if (rxs_d_q && !rxs_q) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (sample_tick) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxs_q, shift_q[7:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (sample_tick) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d    = '0;
                        state_d   = IDLE;
                        stop_done = 1'b1;
                        stop_good = rxs_q;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // An acknowledge arriving with a new byte frees the register, so the byte lands and no overrun is recorded.
    always_comb begin
        rxdata_d    = rxdata_q;
        rxvalid_d   = rxvalid_q;
        overrun_d   = overrun_q;
        frame_err_d = stop_done && !stop_good;
        rxbusy_d    = (state_d != IDLE);

        if (stop_done && stop_good) begin
            if (rxvalid_q && !rxack) begin
                overrun_d = 1'b1;
            end else begin
                rxdata_d  = shift_q;
                rxvalid_d = 1'b1;
                if (rxack) begin
                    overrun_d = 1'b0;
                end
            end
        end else if (rxack && rxvalid_q) begin
            rxvalid_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    assign rxdata    = rxdata_q;
    assign rxvalid   = rxvalid_q;
    assign rxbusy    = rxbusy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
